// File: rtl/cpu_pkg.sv
// Shared CPU definitions: instruction field layout, opcodes, bubble word and fetch states.
package cpu_pkg;

    localparam int unsigned OPC_W    = 5;
    localparam int unsigned WAIT_W   = 11;
    localparam int unsigned OPC_MSB  = 31;
    localparam int unsigned OPC_LSB  = 27;
    localparam int unsigned XBIT     = 26;
    localparam int unsigned WAIT_MSB = 10;

    // Opcodes shared with the control unit
    localparam logic [OPC_W-1:0] OPC_ADD = 5'b00100;
    localparam logic [OPC_W-1:0] OPC_NOP = 5'b01111;

    // Bubble word: NOP opcode, x_bit 0, wait_time 0
    localparam logic [31:0] NOP_INSTR = 32'h7800_0000;

    typedef enum logic [1:0] {
        BOOT   = 2'd0,
        RUN    = 2'd1,
        HALTED = 2'd2
    } fetch_state_e;

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register with load, hold and bubble-inject controls.
module if_id_reg #(
    parameter int unsigned             PC_WIDTH    = 16,
    parameter int unsigned             INSTR_WIDTH = 32,
    parameter logic [PC_WIDTH-1:0]     RESET_PC    = '0,
    parameter logic [INSTR_WIDTH-1:0]  NOP_INSTR   = cpu_pkg::NOP_INSTR
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   load,
    input  logic                   bubble,
    input  logic [INSTR_WIDTH-1:0] instr_d,
    input  logic [PC_WIDTH-1:0]    pc_d,
    output logic [INSTR_WIDTH-1:0] id_instr,
    output logic [PC_WIDTH-1:0]    id_pc,
    output logic [PC_WIDTH-1:0]    id_pc_plus1,
    output logic                   id_valid
);

    // Bubble only replaces the instruction and clears valid; PC fields keep their last value
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            id_instr    <= NOP_INSTR;
            id_pc       <= RESET_PC;
            id_pc_plus1 <= RESET_PC + PC_WIDTH'(1);
            id_valid    <= 1'b0;
        end else if (bubble) begin
            id_instr <= NOP_INSTR;
            id_valid <= 1'b0;
        end else if (load) begin
            id_instr    <= instr_d;
            id_pc       <= pc_d;
            id_pc_plus1 <= pc_d + PC_WIDTH'(1);
            id_valid    <= 1'b1;
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC, synchronous-read imem addressing, IF/ID register and redirect squash.
module fetch_unit
    import cpu_pkg::*;
#(
    parameter int unsigned             PC_WIDTH    = 16,
    parameter int unsigned             INSTR_WIDTH = 32,
    parameter logic [PC_WIDTH-1:0]     RESET_PC    = '0,
    parameter logic [INSTR_WIDTH-1:0]  NOP_INSTR   = cpu_pkg::NOP_INSTR
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   stall,
    input  logic                   halt,
    input  logic                   redirect,
    input  logic [PC_WIDTH-1:0]    redirect_pc,
    output logic [PC_WIDTH-1:0]    imem_addr,
    input  logic [INSTR_WIDTH-1:0] imem_data,
    output logic [INSTR_WIDTH-1:0] id_instr,
    output logic [PC_WIDTH-1:0]    id_pc,
    output logic [PC_WIDTH-1:0]    id_pc_plus1,
    output logic                   id_valid,
    output logic [4:0]             opcode,
    output logic                   x_bit,
    output logic [10:0]            wait_time
);

    fetch_state_e          state;
    logic [PC_WIDTH-1:0]   pc_q;
    logic [PC_WIDTH-1:0]   pc_next;
    logic                  ifid_load;
    logic                  ifid_bubble;

    // Next fetch address and IF/ID control; reset forces the boot address onto the memory
    always_comb begin
        pc_next     = pc_q;
        ifid_load   = 1'b0;
        ifid_bubble = 1'b0;
        if (!rst_n) begin
            pc_next = RESET_PC;
        end else begin
            case (state)
                BOOT: ifid_bubble = 1'b1;
                RUN: begin
                    if (halt) begin
                        ifid_bubble = 1'b1;
                    end else if (!stall) begin
                        if (redirect) begin
                            pc_next     = redirect_pc;
                            ifid_bubble = 1'b1;
                        end else begin
                            pc_next   = pc_q + PC_WIDTH'(1);
                            ifid_load = 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    // Redirect re-enters BOOT to absorb the memory read latency of the new target
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= BOOT;
            pc_q  <= RESET_PC;
        end else begin
            pc_q <= pc_next;
            case (state)
                BOOT:    state <= RUN;
                RUN: begin
                    if (halt)                       state <= HALTED;
                    else if (!stall && redirect)    state <= BOOT;
                end
                default: state <= state;
            endcase
        end
    end

    assign imem_addr = pc_next;

    if_id_reg #(
        .PC_WIDTH    (PC_WIDTH),
        .INSTR_WIDTH (INSTR_WIDTH),
        .RESET_PC    (RESET_PC),
        .NOP_INSTR   (NOP_INSTR)
    ) u_if_id (
        .clk         (clk),
        .rst_n       (rst_n),
        .load        (ifid_load),
        .bubble      (ifid_bubble),
        .instr_d     (imem_data),
        .pc_d        (pc_q),
        .id_instr    (id_instr),
        .id_pc       (id_pc),
        .id_pc_plus1 (id_pc_plus1),
        .id_valid    (id_valid)
    );

    assign opcode    = id_instr[OPC_MSB:OPC_LSB];
    assign x_bit     = id_instr[XBIT];
    assign wait_time = id_instr[WAIT_MSB:0];

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed literal checks plus randomized traffic against a behavioural model.
module tb_fetch_unit;

    localparam logic [31:0] NOP = 32'h7800_0000;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        stall;
    logic        halt;
    logic        redirect;
    logic [15:0] redirect_pc;
    logic [15:0] imem_addr;
    logic [31:0] imem_data;
    logic [31:0] id_instr;
    logic [15:0] id_pc;
    logic [15:0] id_pc_plus1;
    logic        id_valid;
    logic [4:0]  opcode;
    logic        x_bit;
    logic [10:0] wait_time;

    int n_checks = 0;
    int n_fail   = 0;

    logic [31:0] mem [65536];

    fetch_unit dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .stall       (stall),
        .halt        (halt),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .imem_addr   (imem_addr),
        .imem_data   (imem_data),
        .id_instr    (id_instr),
        .id_pc       (id_pc),
        .id_pc_plus1 (id_pc_plus1),
        .id_valid    (id_valid),
        .opcode      (opcode),
        .x_bit       (x_bit),
        .wait_time   (wait_time)
    );

    always #5 clk = ~clk;

    // Synchronous-read instruction memory
    always @(posedge clk) imem_data <= mem[imem_addr];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: a PC, whether the memory word for it is ready yet, and a halted flag
    logic        m_init = 1'b0;
    logic [15:0] m_pc;
    logic        m_ready;
    logic        m_halted;
    logic [31:0] e_instr;
    logic [15:0] e_pc;
    logic [15:0] e_pc1;
    logic        e_valid;

    always @(posedge clk) begin
        if (!rst_n) begin
            m_init   = 1'b1;
            m_pc     = 16'h0000;
            m_ready  = 1'b0;
            m_halted = 1'b0;
            e_instr  = NOP;
            e_pc     = 16'h0000;
            e_pc1    = 16'h0001;
            e_valid  = 1'b0;
        end else if (m_init && !m_halted) begin
            if (!m_ready) begin
                m_ready = 1'b1;
                e_instr = NOP;
                e_valid = 1'b0;
            end else if (halt) begin
                m_halted = 1'b1;
                e_instr  = NOP;
                e_valid  = 1'b0;
            end else if (!stall) begin
                if (redirect) begin
                    m_pc    = redirect_pc;
                    m_ready = 1'b0;
                    e_instr = NOP;
                    e_valid = 1'b0;
                end else begin
                    e_instr = mem[m_pc];
                    e_pc    = m_pc;
                    e_pc1   = 16'(m_pc + 16'd1);
                    e_valid = 1'b1;
                    m_pc    = 16'(m_pc + 16'd1);
                end
            end
        end
    end

    function automatic logic [15:0] exp_addr();
        if (!rst_n)                                   return 16'h0000;
        if (m_halted || !m_ready || halt || stall)    return m_pc;
        if (redirect)                                 return redirect_pc;
        return 16'(m_pc + 16'd1);
    endfunction

    // Per-cycle comparison against the model
    always @(negedge clk) begin
        if (m_init) begin
            chk("m_imem_addr", 32'(imem_addr), 32'(exp_addr()));
            chk("m_id_instr", id_instr, e_instr);
            chk("m_id_pc", 32'(id_pc), 32'(e_pc));
            chk("m_id_pc_plus1", 32'(id_pc_plus1), 32'(e_pc1));
            chk("m_id_valid", 32'(id_valid), 32'(e_valid));
            chk("m_opcode", 32'(opcode), 32'(e_instr[31:27]));
            chk("m_x_bit", 32'(x_bit), 32'(e_instr[26]));
            chk("m_wait_time", 32'(wait_time), 32'(e_instr[10:0]));
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    initial begin
        for (int i = 0; i < 65536; i++) mem[i] = $urandom;
        mem[16'h0000] = 32'h2000_0001;
        mem[16'h0001] = 32'h2000_0002;
        mem[16'h0002] = 32'h2000_0003;
        mem[16'h0003] = 32'h2000_0004;
        mem[16'h0010] = 32'h2000_0010;
        mem[16'h0040] = 32'h2000_0040;
        mem[16'hFFFF] = 32'h2000_0005;

        rst_n = 1'b0; stall = 1'b0; halt = 1'b0; redirect = 1'b0; redirect_pc = 16'h0000;
        repeat (3) cyc();
        @(negedge clk);
        chk("rst_valid", 32'(id_valid), 32'd0);
        chk("rst_instr", id_instr, NOP);
        chk("rst_pc", 32'(id_pc), 32'h0);
        chk("rst_pc1", 32'(id_pc_plus1), 32'h1);
        chk("rst_addr", 32'(imem_addr), 32'h0);

        // Boot latency: first valid instruction two cycles after release
        cyc(); rst_n = 1'b1;
        @(negedge clk); chk("boot_valid", 32'(id_valid), 32'd0); chk("boot_addr", 32'(imem_addr), 32'h0);
        cyc();
        @(negedge clk); chk("run0_valid", 32'(id_valid), 32'd0); chk("run0_addr", 32'(imem_addr), 32'h1);
        cyc();
        @(negedge clk);
        chk("first_valid", 32'(id_valid), 32'd1);
        chk("first_pc", 32'(id_pc), 32'h0);
        chk("first_instr", id_instr, 32'h2000_0001);
        chk("first_opcode", 32'(opcode), 32'h04);
        chk("first_addr", 32'(imem_addr), 32'h2);

        // Stall for three cycles while id_pc=1
        cyc(); stall = 1'b1;
        for (int k = 0; k < 3; k++) begin
            if (k != 0) cyc();
            @(negedge clk);
            chk("stall_pc", 32'(id_pc), 32'h1);
            chk("stall_instr", id_instr, 32'h2000_0002);
            chk("stall_addr", 32'(imem_addr), 32'h2);
        end
        cyc(); stall = 1'b0;
        @(negedge clk); chk("unstall_pc", 32'(id_pc), 32'h1); chk("unstall_addr", 32'(imem_addr), 32'h3);
        cyc();
        redirect = 1'b1; redirect_pc = 16'h0040;
        @(negedge clk);
        chk("post_stall_pc", 32'(id_pc), 32'h2);
        chk("post_stall_instr", id_instr, 32'h2000_0003);
        chk("redir_addr", 32'(imem_addr), 32'h40);

        // Redirect squash
        cyc(); redirect = 1'b0;
        @(negedge clk);
        chk("squash_valid", 32'(id_valid), 32'd0);
        chk("squash_opcode", 32'(opcode), 32'h0F);
        chk("squash_wait", 32'(wait_time), 32'h0);
        cyc();
        @(negedge clk); chk("redir_boot_valid", 32'(id_valid), 32'd0);
        cyc();
        @(negedge clk);
        chk("target_pc", 32'(id_pc), 32'h40);
        chk("target_valid", 32'(id_valid), 32'd1);
        chk("target_instr", id_instr, 32'h2000_0040);

        // Stall and redirect together: redirect waits for the stall to drop
        cyc(); stall = 1'b1; redirect = 1'b1; redirect_pc = 16'h0010;
        @(negedge clk); chk("sr_addr_stall", 32'(imem_addr), 32'h42); chk("sr_pc_stall", 32'(id_pc), 32'h41);
        cyc(); stall = 1'b0;
        @(negedge clk); chk("sr_pc_hold", 32'(id_pc), 32'h41); chk("sr_addr_redir", 32'(imem_addr), 32'h10);
        cyc(); redirect = 1'b0;
        @(negedge clk); chk("sr_bubble", 32'(id_valid), 32'd0);
        cyc();
        cyc();
        @(negedge clk); chk("sr_target_pc", 32'(id_pc), 32'h10); chk("sr_target_valid", 32'(id_valid), 32'd1);

        // Halt is sticky; redirects are ignored
        cyc(); halt = 1'b1;
        @(negedge clk); chk("halt_addr0", 32'(imem_addr), 32'h12);
        cyc(); halt = 1'b0;
        @(negedge clk); chk("halt_valid", 32'(id_valid), 32'd0);
        for (int k = 0; k < 20; k++) begin
            cyc();
            redirect = 1'($urandom_range(0, 1));
            redirect_pc = 16'($urandom);
            @(negedge clk);
            chk("halted_addr", 32'(imem_addr), 32'h12);
            chk("halted_valid", 32'(id_valid), 32'd0);
        end
        cyc(); redirect = 1'b0; rst_n = 1'b0;
        @(negedge clk); chk("rerst_addr", 32'(imem_addr), 32'h0);
        cyc(); rst_n = 1'b1;
        cyc();
        cyc();
        @(negedge clk);
        chk("restart_pc", 32'(id_pc), 32'h0);
        chk("restart_valid", 32'(id_valid), 32'd1);
        chk("restart_instr", id_instr, 32'h2000_0001);

        // PC wrap at 0xFFFF
        cyc(); redirect = 1'b1; redirect_pc = 16'hFFFF;
        cyc(); redirect = 1'b0;
        cyc();
        cyc();
        @(negedge clk);
        chk("wrap_pc", 32'(id_pc), 32'hFFFF);
        chk("wrap_pc1", 32'(id_pc_plus1), 32'h0000);
        chk("wrap_instr", id_instr, 32'h2000_0005);
        chk("wrap_addr", 32'(imem_addr), 32'h0001);
        cyc();
        @(negedge clk);
        chk("wrapped_pc", 32'(id_pc), 32'h0000);
        chk("wrapped_pc1", 32'(id_pc_plus1), 32'h0001);
        chk("wrapped_instr", id_instr, 32'h2000_0001);

        // Randomized traffic checked by the model
        for (int k = 0; k < 3000; k++) begin
            cyc();
            rst_n       = ($urandom_range(0, 199) != 0);
            stall       = ($urandom_range(0, 99) < 25);
            halt        = ($urandom_range(0, 499) == 0);
            redirect    = ($urandom_range(0, 99) < 10);
            redirect_pc = ($urandom_range(0, 3) == 0) ? 16'hFFFE : 16'($urandom);
        end
        @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
